mnist_image_streamer: RTL and testbench
=======================================

# mnist_image_streamer

Streams a finished 28x28 drawing out of `image_memory` into the first neural-network layer. On `start`, it reads all 784 pixel words in raster order through the memory read port (`read_addr` / `data_out`), which has one cycle of read latency. It presents each pixel on a valid/ready stream with its index and a last flag, and counts the nonzero pixels. `busy` tells the drawing grid to stop writing, so the frame stays stable while it is being streamed.

## Interface
- `NUM_PIXELS`, 784: pixels per frame (raster order, index = y*28 + x).
- `ADDR_W`, 16: width of the memory read address.
- `DATA_W`, 32: width of a pixel word (signed).
- `IDX_W`, 10: width of the index and count outputs.

- `CLOCK_50`  in  1: sole clock; every register updates on its rising edge.
- `resetn`  in  1: synchronous, active-low reset.
- `start`  in  1: request to stream one frame; acted on only in IDLE.
- `read_addr`  out  ADDR_W: memory read address.
- `read_data`  in  signed DATA_W: memory `data_out`; returns the word for the address driven one cycle earlier.
- `m_valid`  out  1: a pixel beat is presented.
- `m_ready`  in  1: downstream accepts the beat.
- `m_data`  out  signed DATA_W: pixel value, passed through unmodified.
- `m_index`  out  IDX_W: pixel index, 0..NUM_PIXELS-1.
- `m_last`  out  1: asserted with the beat where `m_index` = NUM_PIXELS-1.
- `busy`  out  1: high from the cycle after `start` is accepted until the cycle `done` pulses.
- `done`  out  1: one-cycle pulse after the last beat is accepted.
- `pixel_count`  out  IDX_W: number of accepted beats with `m_data` != 0.

## Operation
- State IDLE: `busy`=0 and `read_addr`=0.
  - `start`=1 clears `pixel_count`, the issue index and the output index, and moves to STREAM.
- State STREAM: issues reads `read_addr` = 0,1,…,NUM_PIXELS-1, each for one cycle.
  - Read data is captured the next cycle into a 2-entry FIFO holding the data word and its index.
  - Issue rule: issue only while issue index < NUM_PIXELS and (fifo_count + inflight − pop) < 2. Here inflight is the read issued the previous cycle and pop = `m_valid`&`m_ready`.
  - This rule sustains one beat per cycle when `m_ready`=1 and never overflows the FIFO.
  - While no read is issued, `read_addr` holds the last issued address. No beats are lost and none are duplicated.
- Output stream: `m_valid` = FIFO non-empty. `m_data`, `m_index` and `m_last` come from the FIFO head.
  - While `m_valid`=1 and `m_ready`=0, all three must hold stable.
- Pixel count: `pixel_count` increments on each accepted beat with nonzero data. It saturates at NUM_PIXELS and holds its value after `done` until the next accepted `start`.
- State DONE: entered on the cycle after the beat with `m_last` is accepted. `done`=1 and `busy`=0 for that one cycle, then the block returns to IDLE.
- Ignored input: `start` while `busy`=1 has no effect.
- Reset: `resetn`=0 at any time, including mid-frame, forces IDLE and flushes the FIFO and inflight read.
  - Reset values on the next edge: `m_valid`=0, `m_last`=0, `m_data`=0, `m_index`=0, `read_addr`=0, `busy`=0, `done`=0, `pixel_count`=0.
  - Any read returning after reset is discarded.
- Index widths: `m_index` and the issue index are IDX_W wide and never wrap; the last index is 783. `read_addr` is the issue index zero-extended to ADDR_W.

## Timing
- Start-to-output latency: `start` sampled high at edge 0 gives `read_addr`=0 and `busy`=1 during cycle 1. Data is captured at edge 2, so `m_valid`=1 with index 0 during cycle 3 (3 cycles).
- Full throughput: with `m_ready` held at 1, beat k is accepted in cycle 3+k. The last beat (k=783) is accepted in cycle 786 and `done` pulses in cycle 787.
- Outstanding reads: at most 2 reads are ever outstanding or buffered. `read_addr` is never more than 2 ahead of `m_index` of the FIFO head.
- Registered outputs: all outputs are registers; there are no combinational paths from `m_ready` to any output.

## Test plan
- Full frame, no backpressure: memory holds word i = i, and `m_ready`=1. Required: 784 consecutive beats with `m_data`=`m_index`=0..783, first `m_valid` 3 cycles after `start`, `m_last` only at 783, `done` exactly in cycle 787 and `busy` low at the same time.
- Pixel count: memory is 0 except 37 words set to 1, plus one word = −5. Required: `pixel_count`=38 after `done`; `m_data` of −5 is passed through unmodified.
- Random backpressure: `m_ready` is randomized at 50%. Required:
  - beats stay in order with none missing or duplicated;
  - outputs are stable while stalled;
  - `read_addr` − head index ≤ 2 at all times;
  - `done` comes after the 784th accepted beat.
- Start while busy: `start` is pulsed at cycles 10 and 400 mid-frame. Required: no restart, `m_index` continues monotonically, and `pixel_count` is not cleared.
- Reset mid-frame: `resetn`=0 for one cycle at beat 300, then `start` again. Required:
  - all outputs are 0 the cycle after reset;
  - the new frame begins at index 0;
  - no stale data appears.
- Back-to-back frames: `start` is asserted in the cycle right after `done`. Required: the second frame starts 3 cycles later, and `pixel_count` resets to 0 before its first beat.

Source files
------------

// File: rtl/mnist_image_streamer.sv
// mnist_image_streamer
// Reads a finished 28x28 frame out of image memory in raster order and
// presents it as a valid/ready pixel stream with index, last flag and a
// nonzero-pixel count. busy freezes the drawing grid while streaming.
//
// Ports
//   i_clock_50      clock, all registers on its rising edge
//   i_resetn        synchronous active-low reset
//   i_start         stream one frame (honoured only in IDLE)
//   o_read_addr     memory read address (registered)
//   i_read_data     memory data, word for the address of the previous cycle
//   o_m_valid       pixel beat presented
//   i_m_ready       downstream accepts the beat
//   o_m_data        pixel value, unmodified
//   o_m_index       pixel index 0..NUM_PIXELS-1
//   o_m_last        beat carries the final pixel
//   o_busy          frame is being streamed
//   o_done          one-cycle pulse after the final beat is accepted
//   o_pixel_count   accepted beats with nonzero data
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start, read_addr parked at 0
// S_STREAM| issuing reads and emitting beats
// S_DONE  | one-cycle done pulse, then back to idle
module mnist_image_streamer #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 10
) (
    input  logic                     i_clock_50,
    input  logic                     i_resetn,
    input  logic                     i_start,
    output logic [ADDR_W-1:0]        o_read_addr,
    input  logic signed [DATA_W-1:0] i_read_data,
    output logic                     o_m_valid,
    input  logic                     i_m_ready,
    output logic signed [DATA_W-1:0] o_m_data,
    output logic [IDX_W-1:0]         o_m_index,
    output logic                     o_m_last,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [IDX_W-1:0]         o_pixel_count
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_PIXELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:0]        r_read_addr;
    logic [IDX_W-1:0]         r_issue_idx;   // reads issued so far
    logic [IDX_W-1:0]         r_cap_idx;     // next index to be captured
    logic                     r_bus_vld;     // read_data carries an issued address
    logic [IDX_W-1:0]         r_bus_idx;     // index of the word on read_data
    logic                     r_v0, r_v1;
    logic signed [DATA_W-1:0] r_d0, r_d1;
    logic [IDX_W-1:0]         r_i0, r_i1;
    logic                     r_l0, r_l1;
    logic [IDX_W-1:0]         r_count;
    logic                     r_busy, r_done;

    logic             w_pop, w_cap, w_issue, w_stream;
    logic [IDX_W:0]   w_occ;
    logic             w_new_last;

    // Buffered plus uncaptured items after this edge's pop. A new address may
    // only be driven when the word currently on read_addr is guaranteed a
    // FIFO slot next cycle; while held, the memory keeps returning that word.
    assign w_stream   = (r_state == S_STREAM);
    assign w_pop      = r_v0 & i_m_ready;
    assign w_occ      = {1'b0, r_issue_idx - r_cap_idx}
                      + {{IDX_W{1'b0}}, r_v0} + {{IDX_W{1'b0}}, r_v1}
                      - {{IDX_W{1'b0}}, w_pop};
    assign w_issue    = w_stream && (r_issue_idx < NUM_IDX) && (w_occ < (IDX_W+1)'(3));
    assign w_cap      = w_stream && r_bus_vld && (r_bus_idx == r_cap_idx)
                      && (r_cap_idx != r_issue_idx) && (!r_v1 || w_pop);
    assign w_new_last = (r_cap_idx == LAST_IDX);

    always_ff @(posedge i_clock_50) begin
        if (!i_resetn) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start)      w_state_nxt = S_STREAM;
            S_STREAM: if (w_pop && r_l0) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock_50) begin
        if (!i_resetn) begin
            r_read_addr <= '0;
            r_issue_idx <= '0;
            r_cap_idx   <= '0;
            r_bus_vld   <= 1'b0;
            r_bus_idx   <= '0;
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_d0        <= '0;
            r_d1        <= '0;
            r_i0        <= '0;
            r_i1        <= '0;
            r_l0        <= 1'b0;
            r_l1        <= 1'b0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_STREAM);
            r_done <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    r_read_addr <= '0;
                    r_bus_vld   <= 1'b0;
                    if (i_start) begin
                        // address 0 goes out in the first STREAM cycle
                        r_issue_idx <= IDX_W'(1);
                        r_cap_idx   <= '0;
                        r_count     <= '0;
                    end
                end
                S_STREAM: begin
                    r_bus_vld <= 1'b1;
                    r_bus_idx <= r_issue_idx - IDX_W'(1);
                    if (w_issue) begin
                        r_read_addr <= ADDR_W'(r_issue_idx);
                        r_issue_idx <= r_issue_idx + IDX_W'(1);
                    end
                    if (w_cap) r_cap_idx <= r_cap_idx + IDX_W'(1);
                    if (w_pop && (r_d0 != '0) && (r_count != NUM_IDX))
                        r_count <= r_count + IDX_W'(1);

                    // head is entry 0; a pop shifts entry 1 forward
                    if (w_pop) begin
                        if (r_v1) begin
                            r_d0 <= r_d1;
                            r_i0 <= r_i1;
                            r_l0 <= r_l1;
                            if (w_cap) begin
                                r_d1 <= i_read_data;
                                r_i1 <= r_cap_idx;
                                r_l1 <= w_new_last;
                            end else begin
                                r_v1 <= 1'b0;
                            end
                        end else if (w_cap) begin
                            r_d0 <= i_read_data;
                            r_i0 <= r_cap_idx;
                            r_l0 <= w_new_last;
                        end else begin
                            r_v0 <= 1'b0;
                        end
                    end else if (w_cap) begin
                        if (r_v0) begin
                            r_v1 <= 1'b1;
                            r_d1 <= i_read_data;
                            r_i1 <= r_cap_idx;
                            r_l1 <= w_new_last;
                        end else begin
                            r_v0 <= 1'b1;
                            r_d0 <= i_read_data;
                            r_i0 <= r_cap_idx;
                            r_l0 <= w_new_last;
                        end
                    end
                end
                S_DONE: begin
                    r_read_addr <= '0;
                    r_bus_vld   <= 1'b0;
                end
                default: begin
                    r_read_addr <= '0;
                    r_bus_vld   <= 1'b0;
                end
            endcase
        end
    end

    assign o_read_addr   = r_read_addr;
    assign o_m_valid     = r_v0;
    assign o_m_data      = r_d0;
    assign o_m_index     = r_i0;
    assign o_m_last      = r_l0;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_pixel_count = r_count;

endmodule

// File: tb/tb_mnist_image_streamer.sv
module tb_mnist_image_streamer;

    localparam int N = 784;

    logic               clk = 1'b0;
    logic               resetn;
    logic               start;
    logic [15:0]        read_addr;
    logic signed [31:0] read_data;
    logic               m_valid;
    logic               m_ready;
    logic signed [31:0] m_data;
    logic [9:0]         m_index;
    logic               m_last;
    logic               busy;
    logic               done;
    logic [9:0]         pixel_count;

    always #5 clk = ~clk;

    mnist_image_streamer dut (
        .i_clock_50    (clk),
        .i_resetn      (resetn),
        .i_start       (start),
        .o_read_addr   (read_addr),
        .i_read_data   (read_data),
        .o_m_valid     (m_valid),
        .i_m_ready     (m_ready),
        .o_m_data      (m_data),
        .o_m_index     (m_index),
        .o_m_last      (m_last),
        .o_busy        (busy),
        .o_done        (done),
        .o_pixel_count (pixel_count)
    );

    // image memory with one cycle of read latency
    logic signed [31:0] mem [0:N-1];
    always @(posedge clk) begin
        read_data <= mem[(int'(read_addr) < N) ? int'(read_addr) : 0];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_mem(input int pat);
        for (int i = 0; i < N; i++) begin
            case (pat)
                0:       mem[i] = i;
                2:       mem[i] = -1;
                default: mem[i] = 0;
            endcase
        end
        if (pat == 1) begin
            for (int k = 0; k < 37; k++) mem[5*k + 3] = 1;
            mem[500] = -5;
        end
    endtask

    // Starts one frame and follows it to done, checking the stream on the way.
    task automatic run_frame(input string tag, input int pat, input int rmode,
                             input int extra_start, input int exp_count,
                             input int exp_done);
        int cyc, exp_idx, first_cyc, done_cyc, last_acc;
        int order_err, stall_err, dist_err, last_err, busy_err;
        logic prev_stall;
        logic signed [31:0] s_data;
        logic [9:0] s_idx;
        logic s_last;
        logic signed [31:0] data500;
        exp_idx = 0; first_cyc = -1; done_cyc = -1; last_acc = -1;
        order_err = 0; stall_err = 0; dist_err = 0; last_err = 0; busy_err = 0;
        prev_stall = 1'b0; s_data = 0; s_idx = 0; s_last = 0; data500 = 0;
        fill_mem(pat);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        check({tag, "_c1_busy"}, busy, 1);
        check({tag, "_c1_addr"}, read_addr, 0);
        check({tag, "_c1_count_clr"}, pixel_count, 0);
        while (1) begin
            if (cyc > 4000) begin
                n_tests++; n_fail++;
                $display("FAIL %s_timeout: got no done within %0d cycles", tag, cyc);
                break;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!busy) busy_err++;
            if (prev_stall && (!m_valid || m_data !== s_data || m_index !== s_idx || m_last !== s_last))
                stall_err++;
            if (m_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (int'(read_addr) - int'(m_index) > 2 || int'(read_addr) < int'(m_index))
                    dist_err++;
                if (m_last !== (m_index == 10'(N-1))) last_err++;
            end
            start = (extra_start != 0 && (cyc == 10 || cyc == 400)) ? 1'b1 : 1'b0;
            m_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (m_valid && m_ready) begin
                if (exp_idx >= N || int'(m_index) != exp_idx || m_data !== mem[exp_idx])
                    order_err++;
                if (int'(m_index) == 500) data500 = m_data;
                exp_idx++;
                last_acc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            s_data = m_data; s_idx = m_index; s_last = m_last;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        m_ready = 1'b1;
        check({tag, "_beats"}, exp_idx, N);
        check({tag, "_order"}, order_err, 0);
        check({tag, "_stall_hold"}, stall_err, 0);
        check({tag, "_addr_ahead"}, dist_err, 0);
        check({tag, "_last_flag"}, last_err, 0);
        check({tag, "_busy_during"}, busy_err, 0);
        check({tag, "_first_valid_cyc"}, first_cyc, 3);
        check({tag, "_done_after_last"}, done_cyc, last_acc + 1);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_valid_at_done"}, m_valid, 0);
        check({tag, "_pixel_count"}, pixel_count, exp_count);
        if (exp_done > 0) check({tag, "_done_cyc"}, done_cyc, exp_done);
        if (pat == 1) check({tag, "_neg5_pass"}, data500, -5);
    endtask

    typedef struct {
        int pat;
        int rmode;
        int extra_start;
        int exp_count;
        int exp_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // pat 0: word i = i; 1: 37 ones + one -5; 2: all -1; 3: all zero
        vecs[0] = '{pat: 0, rmode: 0, extra_start: 0, exp_count: 783, exp_done: 787};
        vecs[1] = '{pat: 1, rmode: 0, extra_start: 0, exp_count: 38,  exp_done: 787};
        vecs[2] = '{pat: 0, rmode: 1, extra_start: 0, exp_count: 783, exp_done: -1};
        vecs[3] = '{pat: 2, rmode: 1, extra_start: 0, exp_count: 784, exp_done: -1};
        vecs[4] = '{pat: 1, rmode: 0, extra_start: 1, exp_count: 38,  exp_done: 787};
        vecs[5] = '{pat: 3, rmode: 0, extra_start: 0, exp_count: 0,   exp_done: 787};

        resetn = 1'b0; start = 1'b0; m_ready = 1'b1;
        fill_mem(3);
        repeat (3) @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_addr", read_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", pixel_count, 0);
        resetn = 1'b1;
        @(negedge clk);

        // consecutive rows start in the cycle right after the previous done
        for (int i = 0; i < 6; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].pat, vecs[i].rmode,
                      vecs[i].extra_start, vecs[i].exp_count, vecs[i].exp_done);

        // frame held after done: count stays until the next start
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_addr", read_addr, 0);
        check("idle_count_hold", pixel_count, 0);

        // reset in the middle of a frame
        fill_mem(0);
        m_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        begin
            int w;
            w = 0;
            while (!(m_valid && m_index == 10'd300) && w < 1000) begin
                @(negedge clk);
                w++;
            end
            check("midrst_reach_300", m_index, 300);
        end
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_valid", m_valid, 0);
        check("midrst_last", m_last, 0);
        check("midrst_data", m_data, 0);
        check("midrst_index", m_index, 0);
        check("midrst_addr", read_addr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_count", pixel_count, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("postrst_idle_valid", m_valid, 0);
        run_frame("after_rst", 1, 1, 0, 38, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
